// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and its controller/datapath peers.
package mem_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_e;

endpackage : mem_pkg

// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle controller and the memory responder.
interface mem_responder_if
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (
      output mem_read, mem_write, addr, wdata,
      input  rdata, ready, busy, err
   );

   modport slave (
      input  mem_read, mem_write, addr, wdata,
      output rdata, ready, busy, err
   );

endinterface : mem_responder_if

// File: rtl/mem_array.sv
// Unified instruction/data storage: synchronous write, combinational read.
module mem_array #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata_c
);

   // Contents are deliberately not reset.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata_c = mem[addr];

endmodule : mem_array

// File: rtl/mem_responder.sv
// Serves controller read/write requests after WAIT_CYCLES wait states and
// returns a one-cycle ready pulse; malformed read+write requests raise err.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic              enter_resp;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata_c;

   // State register plus registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Next state, wait counter and request latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.mem_read ^ bus.mem_write) begin
               op_wr_d = bus.mem_write;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs and memory access, all keyed off the edge that enters RESP.
   always_comb begin
      enter_resp = 1'b0;
      mem_we     = 1'b0;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      busy_d     = 1'b0;
      err_d      = 1'b0;
      enter_resp = (state_d == RESP) && (state_q != RESP);
      mem_we     = enter_resp && op_wr_d;
      if (enter_resp && !op_wr_d) begin
         rdata_d = mem_rdata_c;
      end
      ready_d = (state_d == RESP);
      busy_d  = (state_d != IDLE);
      err_d   = (state_q == IDLE) && bus.mem_read && bus.mem_write;
   end

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem_array (
      .clk     (clk),
      .we      (mem_we),
      .addr    (addr_d),
      .wdata   (wdata_d),
      .rdata_c (mem_rdata_c)
   );

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Directed bench: per-cycle vector table on a 2-wait-state responder plus
// hand sequences for held requests, zero wait states and reset mid-access.
module tb_mem_responder;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus2 ();
   mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus0 ();

   mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic        e_ready;
      logic        e_busy;
      logic        e_err;
      logic [15:0] e_rdata;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive2(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
      bus2.mem_read  = rd;
      bus2.mem_write = wr;
      bus2.addr      = a;
      bus2.wdata     = d;
   endtask

   task automatic drive0(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
      bus0.mem_read  = rd;
      bus0.mem_write = wr;
      bus0.addr      = a;
      bus0.wdata     = d;
   endtask

   // One complete access on the 2-wait-state instance, bounded wait for ready.
   task automatic do_op2(input logic wr, input logic [7:0] a, input logic [15:0] d);
      int k;
      drive2(!wr, wr, a, d);
      step();
      drive2(1'b0, 1'b0, 8'h00, 16'h0000);
      k = 0;
      while (bus2.ready !== 1'b1 && k < 10) begin
         step();
         k++;
      end
      chk("op_done", 16'(bus2.ready), 16'h0001);
      step();
   endtask

   task automatic add(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d,
                      input logic er, input logic eb, input logic ee, input logic [15:0] erd);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
      v.e_ready = er; v.e_busy = eb; v.e_err = ee; v.e_rdata = erd;
      vq.push_back(v);
   endtask

   initial begin
      int rdy_cnt;
      logic exp_rdy;

      drive2(1'b0, 1'b0, 8'h00, 16'h0000);
      drive0(1'b0, 1'b0, 8'h00, 16'h0000);

      //      rd wr addr   wdata    rdy busy err rdata
      add(0, 1, 8'h12, 16'hBEEF, 0, 1, 0, 16'h0000);
      add(0, 0, 8'h00, 16'h0000, 0, 1, 0, 16'h0000);
      add(0, 0, 8'h00, 16'h0000, 1, 1, 0, 16'h0000);
      add(0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h0000);
      add(1, 0, 8'h12, 16'h0000, 0, 1, 0, 16'h0000);
      add(0, 0, 8'h00, 16'h0000, 0, 1, 0, 16'h0000);
      add(0, 0, 8'h00, 16'h0000, 1, 1, 0, 16'hBEEF);
      add(0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'hBEEF);
      add(0, 1, 8'h20, 16'h5A5A, 0, 1, 0, 16'hBEEF);
      add(0, 0, 8'h00, 16'h0000, 0, 1, 0, 16'hBEEF);
      add(0, 0, 8'h00, 16'h0000, 1, 1, 0, 16'hBEEF);
      add(0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'hBEEF);
      add(1, 1, 8'h20, 16'hFFFF, 0, 0, 1, 16'hBEEF);
      add(0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'hBEEF);
      add(1, 0, 8'h20, 16'h0000, 0, 1, 0, 16'hBEEF);
      add(0, 0, 8'h00, 16'h0000, 0, 1, 0, 16'hBEEF);
      add(0, 0, 8'h00, 16'h0000, 1, 1, 0, 16'h5A5A);
      add(0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h5A5A);
      add(0, 1, 8'h30, 16'h1234, 0, 1, 0, 16'h5A5A);
      add(0, 0, 8'h00, 16'h0000, 0, 1, 0, 16'h5A5A);
      add(0, 0, 8'h00, 16'h0000, 1, 1, 0, 16'h5A5A);
      add(0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h5A5A);
      add(1, 0, 8'h30, 16'h0000, 0, 1, 0, 16'h5A5A);
      add(0, 1, 8'h30, 16'hFFFF, 0, 1, 0, 16'h5A5A);
      add(0, 1, 8'h30, 16'hFFFF, 1, 1, 0, 16'h1234);
      add(0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h1234);
      add(1, 0, 8'h30, 16'h0000, 0, 1, 0, 16'h1234);
      add(0, 0, 8'h00, 16'h0000, 0, 1, 0, 16'h1234);
      add(0, 0, 8'h00, 16'h0000, 1, 1, 0, 16'h1234);
      add(0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h1234);

      // Reset values.
      step();
      step();
      chk("rst.ready", 16'(bus2.ready), 16'h0000);
      chk("rst.busy",  16'(bus2.busy),  16'h0000);
      chk("rst.err",   16'(bus2.err),   16'h0000);
      chk("rst.rdata", bus2.rdata,      16'h0000);
      chk("rst0.busy", 16'(bus0.busy),  16'h0000);
      @(negedge clk);
      reset = 1'b1;

      // Table-driven per-cycle vectors.
      foreach (vq[i]) begin
         drive2(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wdata);
         step();
         chk($sformatf("v%0d.ready", i), 16'(bus2.ready), 16'(vq[i].e_ready));
         chk($sformatf("v%0d.busy", i),  16'(bus2.busy),  16'(vq[i].e_busy));
         chk($sformatf("v%0d.err", i),   16'(bus2.err),   16'(vq[i].e_err));
         chk($sformatf("v%0d.rdata", i), bus2.rdata,      vq[i].e_rdata);
      end
      drive2(1'b0, 1'b0, 8'h00, 16'h0000);
      step();

      // Held read for 8 edges: completions after the 3rd and 7th edge.
      drive2(1'b1, 1'b0, 8'h12, 16'h0000);
      rdy_cnt = 0;
      for (int e = 0; e < 8; e++) begin
         step();
         exp_rdy = (e == 2) || (e == 6);
         chk($sformatf("hold.e%0d.ready", e), 16'(bus2.ready), 16'(exp_rdy));
         if (bus2.ready === 1'b1) begin
            rdy_cnt++;
            chk($sformatf("hold.e%0d.rdata", e), bus2.rdata, 16'hBEEF);
         end
      end
      chk("hold.count", 16'(rdy_cnt), 16'd2);
      drive2(1'b0, 1'b0, 8'h00, 16'h0000);
      step();
      chk("hold.idle", 16'(bus2.busy), 16'h0000);

      // Zero wait states: ready and busy for exactly one cycle.
      drive0(1'b0, 1'b1, 8'h40, 16'hA5A5);
      step();
      chk("w0.wr.ready", 16'(bus0.ready), 16'h0001);
      chk("w0.wr.busy",  16'(bus0.busy),  16'h0001);
      drive0(1'b0, 1'b0, 8'h00, 16'h0000);
      step();
      chk("w0.wr.ready2", 16'(bus0.ready), 16'h0000);
      drive0(1'b1, 1'b0, 8'h40, 16'h0000);
      step();
      chk("w0.rd.ready", 16'(bus0.ready), 16'h0001);
      chk("w0.rd.busy",  16'(bus0.busy),  16'h0001);
      chk("w0.rd.rdata", bus0.rdata,      16'hA5A5);
      drive0(1'b0, 1'b0, 8'h00, 16'h0000);
      step();
      chk("w0.rd.busy2", 16'(bus0.busy),  16'h0000);
      chk("w0.rd.hold",  bus0.rdata,      16'hA5A5);

      // Reset during WAIT of a write: the write must never land.
      do_op2(1'b1, 8'h10, 16'h0000);
      drive2(1'b0, 1'b1, 8'h10, 16'hBEEF);
      step();
      drive2(1'b0, 1'b0, 8'h00, 16'h0000);
      chk("rw.busy", 16'(bus2.busy), 16'h0001);
      #2;
      reset = 1'b0;
      #1;
      chk("rw.rst.busy",  16'(bus2.busy),  16'h0000);
      chk("rw.rst.rdata", bus2.rdata,      16'h0000);
      @(negedge clk);
      reset = 1'b1;
      drive2(1'b1, 1'b0, 8'h10, 16'h0000);
      step();
      drive2(1'b0, 1'b0, 8'h00, 16'h0000);
      rdy_cnt = 0;
      for (int e = 0; e < 6; e++) begin
         if (bus2.ready === 1'b1) rdy_cnt++;
         step();
      end
      chk("rw.ready_count", 16'(rdy_cnt),  16'd1);
      chk("rw.rdata",       bus2.rdata,    16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_mem_responder
